// File: rtl/switch_input_port.sv
// Switch/button input peripheral: 2-flop synchronizer, tick-based debounce,
// sticky rising-edge flags, interrupt mask and a 4-register read/write bus.
module switch_input_port #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned SAMPLES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SW,
  input  logic             sel,
  input  logic             re,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam int unsigned CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0]  REG_DATA  = 2'd0;
  localparam logic [1:0]  REG_EDGE  = 2'd1;
  localparam logic [1:0]  REG_MASK  = 2'd2;
  localparam logic [1:0]  REG_RAW   = 2'd3;

  logic [WIDTH-1:0]                sync_meta;
  logic [WIDTH-1:0]                sync_sw;
  logic [CNT_W-1:0]                cnt;
  logic                            tick_c;
  logic [SAMPLES-1:0][WIDTH-1:0]   hist;
  logic [SAMPLES-1:0][WIDTH-1:0]   hist_nxt_c;
  logic [WIDTH-1:0]                all_one_c;
  logic [WIDTH-1:0]                all_zero_c;
  logic [WIDTH-1:0]                db;
  logic [WIDTH-1:0]                db_prev;
  logic [WIDTH-1:0]                rise_c;
  logic [WIDTH-1:0]                edge_flags;
  logic [WIDTH-1:0]                mask_bits;
  logic [WIDTH-1:0]                edge_clr_c;
  logic                            wr_c;
  logic                            rd_c;
  logic [31:0]                     rd_mux_c;
  logic                            unused_bits;

  // Low address bits are don't-care and upper write-data bits may be unused
  assign unused_bits = ^{addr[1:0], wdata};

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_sw   <= '0;
    end else begin
      sync_meta <= SW;
      sync_sw   <= sync_meta;
    end
  end

  // Debounce sample strobe, one cycle in every TICK_DIV
  assign tick_c = (cnt == CNT_W'(TICK_DIV - 1));

  // Prescaler counting 0..TICK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Post-shift history and per-bit unanimity (includes the sample taken this tick)
  always_comb begin
    hist_nxt_c = {hist[SAMPLES-2:0], sync_sw};
    all_one_c  = '1;
    all_zero_c = '1;
    for (int k = 0; k < int'(SAMPLES); k++) begin
      all_one_c  = all_one_c & hist_nxt_c[k];
      all_zero_c = all_zero_c & ~hist_nxt_c[k];
    end
  end

  // Sample history and debounced level, updated on tick only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      db   <= '0;
    end else if (tick_c) begin
      hist <= hist_nxt_c;
      db   <= (db & ~all_zero_c) | all_one_c;
    end
  end

  // Bus decode, W1C clear mask and rising-edge detect
  always_comb begin
    wr_c       = sel & we;
    rd_c       = sel & re;
    edge_clr_c = (wr_c && addr[3:2] == REG_EDGE) ? wdata[WIDTH-1:0] : '0;
    rise_c     = db & ~db_prev;
  end

  // Sticky edge flags (set beats clear), mask register, irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_prev    <= '0;
      edge_flags <= '0;
      mask_bits  <= '0;
      irq        <= 1'b0;
    end else begin
      db_prev    <= db;
      edge_flags <= (edge_flags & ~edge_clr_c) | rise_c;
      if (wr_c && addr[3:2] == REG_MASK) begin
        mask_bits <= wdata[WIDTH-1:0];
      end
      irq <= |(edge_flags & mask_bits);
    end
  end

  // Read mux over pre-write register values
  always_comb begin
    rd_mux_c = '0;
    case (addr[3:2])
      REG_DATA: rd_mux_c = 32'(db);
      REG_EDGE: rd_mux_c = 32'(edge_flags);
      REG_MASK: rd_mux_c = 32'(mask_bits);
      REG_RAW:  rd_mux_c = 32'(sync_sw);
      default:  rd_mux_c = '0;
    endcase
  end

  // Registered read data, holds while not reading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_c) begin
      rdata <= rd_mux_c;
    end
  end

endmodule
